// File: rtl/bitdensity_pkg.sv
// bitdensity_pkg
//   Shared types and constants for the bit-density encoder.
//   - state_t    : encoder FSM states (IDLE, RUN)
//   - LFSR_*     : width, tap mask and reset seed of the dither LFSR
//                  (only consumed when BITDENSITY_DITHER_EN is defined)
package bitdensity_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int              LFSR_WIDTH = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

endpackage

// File: rtl/bitdensity_encoder_lfsr16.sv
// lfsr16
//   16-bit Fibonacci LFSR used to randomise the accumulator start phase.
//   Only instantiated when BITDENSITY_DITHER_EN is defined.
//   Ports:
//     clk   in   clock
//     rst   in   synchronous active-high reset (loads LFSR_SEED)
//     en    in   advance one step
//     lfsr  out  current register contents
module lfsr16
  import bitdensity_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [LFSR_WIDTH-1:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/bitdensity_encoder.sv
// bitdensity_encoder
//   Accepts a ones-count and serially emits an NDATA-bit frame holding
//   exactly that many 1s, spread evenly by a first-order (Bresenham)
//   accumulator.
//   Optional: define BITDENSITY_DITHER_EN to start each frame's
//   accumulator from an LFSR value, varying the phase frame to frame.
//   Ports:
//     clk          in   clock
//     rst          in   synchronous active-high reset
//     count_in     in   requested ones per frame (saturated to NDATA)
//     count_valid  in   count_in valid
//     count_ready  out  encoder idle, can take a count
//     bit_out      out  current frame bit
//     bit_valid    out  bit_out valid
//     bit_ready    in   downstream accepts bit_out
//     frame_last   out  marks the final bit of the frame
//     busy         out  frame in progress
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | waiting for a count, outputs quiet
//   RUN   | emitting frame bits, one per bit handshake
module bitdensity_encoder
  import bitdensity_pkg::*;
#(
  parameter int NDATA     = 128,
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NDATA_LOG:0] count_in,
  input  logic               count_valid,
  output logic               count_ready,
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               frame_last,
  output logic               busy
);

  localparam logic [NDATA_LOG:0]   CNT_FULL = (NDATA_LOG+1)'(NDATA);
  localparam logic [NDATA_LOG+1:0] SUM_FULL = (NDATA_LOG+2)'(NDATA);
  localparam logic [NDATA_LOG-1:0] IDX_LAST = (NDATA_LOG)'(NDATA - 1);
  localparam logic [NDATA_LOG-1:0] IDX_ONE  = (NDATA_LOG)'(1);

  state_t               state, state_nxt;
  logic [NDATA_LOG:0]   cnt;
  logic [NDATA_LOG-1:0] acc;
  logic [NDATA_LOG-1:0] idx;
  logic [NDATA_LOG-1:0] acc_seed;
  logic [NDATA_LOG+1:0] sum;
  logic                 bit_calc;
  logic                 count_take;
  logic                 bit_take;
  logic                 at_last;

  assign sum        = {2'b00, acc} + {1'b0, cnt};
  assign bit_calc   = (sum >= SUM_FULL);
  assign at_last    = (idx == IDX_LAST);
  assign count_take = count_valid && count_ready;
  assign bit_take   = bit_valid && bit_ready;

`ifdef BITDENSITY_DITHER_EN
  logic [LFSR_WIDTH-1:0] lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (count_take),
    .lfsr (lfsr)
  );

  // Seed is below NDATA, so the ones count per frame is unchanged.
  assign acc_seed = lfsr[NDATA_LOG-1:0];
`else
  assign acc_seed = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count_take) state_nxt = RUN;
      RUN:     if (bit_take && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: all derived from registers, no input-to-output path
  always_comb begin
    count_ready = 1'b0;
    bit_valid   = 1'b0;
    busy        = 1'b0;
    bit_out     = 1'b0;
    frame_last  = 1'b0;
    case (state)
      IDLE: count_ready = 1'b1;
      RUN: begin
        bit_valid  = 1'b1;
        busy       = 1'b1;
        bit_out    = bit_calc;
        frame_last = at_last;
      end
      default: count_ready = 1'b0;
    endcase
  end

  // Datapath. Subtracting NDATA on a 1-bit is the same as taking
  // (acc + cnt) modulo NDATA, so the low bits of cnt suffice here.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      idx <= '0;
    end else if (count_take) begin
      cnt <= (count_in > CNT_FULL) ? CNT_FULL : count_in;
      acc <= acc_seed;
      idx <= '0;
    end else if (bit_take) begin
      acc <= acc + cnt[NDATA_LOG-1:0];
      idx <= at_last ? '0 : idx + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_bitdensity_encoder.sv
module tb_bitdensity_encoder;

  localparam int NDATA     = 128;
  localparam int NDATA_LOG = $clog2(NDATA);

  logic               clk = 1'b0;
  logic               rst;
  logic [NDATA_LOG:0] count_in;
  logic               count_valid;
  logic               count_ready;
  logic               bit_out;
  logic               bit_valid;
  logic               bit_ready;
  logic               frame_last;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic sb[$];
  logic frame_bits[NDATA];
  logic ref_bits[NDATA];
  int   f_ones;
  int   f_first;
  int   f_lasts;
  int   firsts[10];

  bitdensity_encoder #(.NDATA(NDATA)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .frame_last  (frame_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Ideal even spreading starting from phase 0: bit i is 1 when the
  // running quota floor((i+1)*c/N) steps past floor(i*c/N).
  function automatic logic model_bit(input int i, input int c);
    return (((i + 1) * c) / NDATA) != ((i * c) / NDATA);
  endfunction

  // Drives one count, collects the frame at negedges; optionally aborts
  // with reset once abort_at bits have been transferred.
  task automatic run_frame(input int c, input int stall_pct, input int abort_at);
    int   got;
    int   cyc;
    int   csat;
    logic prev_stall;
    logic prev_bit;
    logic prev_last;
    logic exp_bit;
    csat = (c > NDATA) ? NDATA : c;
    cyc = 0;
    while (!count_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("count_ready_before_frame", count_ready, 1);
    count_in    = (NDATA_LOG+1)'(c);
    count_valid = 1'b1;
    bit_ready   = 1'b0;
    @(negedge clk);
    count_valid = 1'b0;
    check("first_bit_valid_latency", bit_valid, 1);
    check("busy_in_run", busy, 1);
    check("count_ready_in_run", count_ready, 0);
`ifndef BITDENSITY_DITHER_EN
    for (int i = 0; i < NDATA; i++) sb.push_back(model_bit(i, csat));
`endif
    got = 0; f_ones = 0; f_first = -1; f_lasts = 0;
    prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
    bit_ready = ($urandom_range(99) >= stall_pct);
    cyc = 0;
    while (got < NDATA && cyc < 20 * NDATA) begin
      if (abort_at >= 0 && got == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bit_valid", bit_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_count_ready", count_ready, 1);
        check("abort_frame_last", frame_last, 0);
        sb.delete();
        return;
      end
      if (prev_stall) begin
        check("stall_hold_bit", bit_out, prev_bit);
        check("stall_hold_last", frame_last, prev_last);
      end
      if (bit_valid && bit_ready) begin
        frame_bits[got] = bit_out;
        if (bit_out) begin
          f_ones++;
          if (f_first < 0) f_first = got;
        end
        if (frame_last) f_lasts++;
        check("frame_last_position", frame_last, (got == NDATA - 1));
`ifndef BITDENSITY_DITHER_EN
        if (sb.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          exp_bit = sb.pop_front();
          check("frame_bit", bit_out, exp_bit);
        end
`endif
        got++;
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      prev_last  = frame_last;
      @(negedge clk);
      cyc++;
      bit_ready = ($urandom_range(99) >= stall_pct);
    end
    check("frame_completed", got, NDATA);
    check("frame_ones", f_ones, csat);
    check("frame_last_count", f_lasts, 1);
    check("count_ready_after_frame", count_ready, 1);
    check("busy_after_frame", busy, 0);
    check("bit_valid_after_frame", bit_valid, 0);
    bit_ready = 1'b0;
  endtask

  initial begin
    int diffs;
    int all_same;
    rst         = 1'b1;
    count_in    = '0;
    count_valid = 1'b0;
    bit_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count_ready", count_ready, 1);
    check("reset_bit_valid", bit_valid, 0);
    check("reset_frame_last", frame_last, 0);
    check("reset_busy", busy, 0);
    check("reset_bit_out", bit_out, 0);
    rst = 1'b0;
    @(negedge clk);

`ifndef BITDENSITY_DITHER_EN
    run_frame(0, 0, -1);
    check("cnt0_no_ones", f_ones, 0);
    run_frame(128, 0, -1);
    check("cnt128_first_one", f_first, 0);
    run_frame(1, 0, -1);
    check("cnt1_one_at_last", f_first, NDATA - 1);
    run_frame(64, 0, -1);
    diffs = 0;
    for (int i = 0; i < NDATA; i++) if (frame_bits[i] !== logic'(i % 2)) diffs++;
    check("cnt64_alternating", diffs, 0);
    run_frame(200, 0, -1);
    check("cnt200_saturated_first", f_first, 0);
    run_frame(37, 0, -1);
    for (int i = 0; i < NDATA; i++) ref_bits[i] = frame_bits[i];
    run_frame(37, 50, -1);
    diffs = 0;
    for (int i = 0; i < NDATA; i++) if (frame_bits[i] !== ref_bits[i]) diffs++;
    check("stall_matches_nostall", diffs, 0);
    run_frame(10, 0, 50);
    run_frame(5, 0, -1);
`else
    run_frame(10, 0, 50);
    run_frame(5, 0, -1);
    for (int f = 0; f < 10; f++) begin
      run_frame(10, 0, -1);
      firsts[f] = f_first;
    end
    all_same = 1;
    for (int f = 1; f < 10; f++) if (firsts[f] != firsts[0]) all_same = 0;
    check("dither_phase_varies", all_same, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
